decode_stage: RTL and testbench

Pipelined A64 decode stage sitting directly upstream of `reg_file`. It accepts a fetched 32-bit instruction and PC over a valid/ready handshake. It decodes a fixed 64-bit integer subset into register-file controls (`Read_register_1/2`, `Write_register`, `RegWrite`, `UseSP`), an op code and a sign-/zero-extended immediate. The result is held in a single-entry pipeline register with stall and flush.

---
 rtl/decode_stage.sv | 155 +++++++++++++++
 tb/tb_decode_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: decodes a fixed A64 integer subset into reg_file controls,
// an op code and an extended immediate, held in a single-entry
// valid/ready pipeline register with stall and flush.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [63:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [4:0]  Read_register_1,
    output logic [4:0]  Read_register_2,
    output logic [4:0]  Write_register,
    output logic        RegWrite,
    output logic        UseSP,
    output logic        alu_src,
    output logic [3:0]  op,
    output logic [63:0] imm,
    output logic        illegal
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_LDUR = 4'd3,
        OP_STUR = 4'd4,
        OP_MOVZ = 4'd5,
        OP_CBZ  = 4'd6,
        OP_B    = 4'd7
    } op_e;

    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    op_e         d_op;
    logic [4:0]  d_rr1;
    logic [4:0]  d_rr2;
    logic [4:0]  d_wr;
    logic        d_rw;
    logic        d_sp;
    logic        d_alu;
    logic        d_ill;
    logic [63:0] d_imm;
    logic        want_wr;
    logic        accept;

    assign rd = in_instr[4:0];
    assign rn = in_instr[9:5];
    assign rm = in_instr[20:16];

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Combinational decode of the presented instruction; first match wins.
    always_comb begin
        d_op    = OP_NOP;
        d_rr1   = rn;
        d_rr2   = 5'd31;
        d_wr    = 5'd31;
        d_rw    = 1'b0;
        d_sp    = 1'b0;
        d_alu   = 1'b0;
        d_ill   = 1'b0;
        d_imm   = '0;
        want_wr = 1'b0;
        if ((in_instr & 32'hFF800000) == 32'h91000000 ||
            (in_instr & 32'hFF800000) == 32'hD1000000) begin
            d_op    = in_instr[30] ? OP_SUB : OP_ADD;
            d_imm   = {52'd0, in_instr[21:10]} << (in_instr[22] ? 6'd12 : 6'd0);
            d_sp    = 1'b1;
            d_alu   = 1'b1;
            want_wr = 1'b1;
        end else if ((in_instr & 32'hFFE0FC00) == 32'h8B000000 ||
                     (in_instr & 32'hFFE0FC00) == 32'hCB000000) begin
            d_op    = in_instr[30] ? OP_SUB : OP_ADD;
            d_rr2   = rm;
            want_wr = 1'b1;
        end else if ((in_instr & 32'hFFE00C00) == 32'hF8400000) begin
            d_op    = OP_LDUR;
            d_imm   = {{55{in_instr[20]}}, in_instr[20:12]};
            d_sp    = 1'b1;
            d_alu   = 1'b1;
            want_wr = 1'b1;
        end else if ((in_instr & 32'hFFE00C00) == 32'hF8000000) begin
            // One UseSP bit cannot mean SP for Rn and XZR for Rt at once.
            if (rn == 5'd31 && rd == 5'd31) begin
                d_ill = 1'b1;
            end else begin
                d_op  = OP_STUR;
                d_rr2 = rd;
                d_imm = {{55{in_instr[20]}}, in_instr[20:12]};
                d_sp  = (rn == 5'd31);
                d_alu = 1'b1;
            end
        end else if ((in_instr & 32'hFF800000) == 32'hD2800000) begin
            d_op    = OP_MOVZ;
            d_imm   = {48'd0, in_instr[20:5]} << {in_instr[22:21], 4'b0000};
            d_alu   = 1'b1;
            want_wr = 1'b1;
        end else if ((in_instr & 32'hFF000000) == 32'hB4000000) begin
            d_op  = OP_CBZ;
            d_rr1 = rd;
            d_imm = {{43{in_instr[23]}}, in_instr[23:5], 2'b00};
        end else if ((in_instr & 32'hFC000000) == 32'h14000000) begin
            d_op  = OP_B;
            d_imm = {{36{in_instr[25]}}, in_instr[25:0], 2'b00};
        end else begin
            d_ill = 1'b1;
        end
        // A write to register 31 in XZR mode is dropped.
        if (want_wr && !(rd == 5'd31 && !d_sp)) begin
            d_rw = 1'b1;
            d_wr = rd;
        end
    end

    // Pipeline register: flush beats accept, accept beats consume; stall holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_pc          <= '0;
            op              <= OP_NOP;
            imm             <= '0;
            Read_register_1 <= 5'd31;
            Read_register_2 <= 5'd31;
            Write_register  <= 5'd31;
            RegWrite        <= 1'b0;
            UseSP           <= 1'b0;
            alu_src         <= 1'b0;
            illegal         <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid       <= 1'b1;
            out_pc          <= in_pc;
            op              <= d_op;
            imm             <= d_imm;
            Read_register_1 <= d_rr1;
            Read_register_2 <= d_rr2;
            Write_register  <= d_wr;
            RegWrite        <= d_rw;
            UseSP           <= d_sp;
            alu_src         <= d_alu;
            illegal         <= d_ill;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// table-driven reference decoder and an in-order scoreboard.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [4:0]  Read_register_1;
    logic [4:0]  Read_register_2;
    logic [4:0]  Write_register;
    logic        RegWrite;
    logic        UseSP;
    logic        alu_src;
    logic [3:0]  op;
    logic [63:0] imm;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [4:0]  wr;
        logic        rw;
        logic        sp;
        logic        alu;
        logic [63:0] imm;
        logic        ill;
    } dec_t;

    typedef struct {
        dec_t        e;
        dec_t        m;
        logic [63:0] pc;
    } item_t;

    localparam dec_t RESET_VAL = '{op: 4'd0, rr1: 5'd31, rr2: 5'd31, wr: 5'd31,
                                   rw: 1'b0, sp: 1'b0, alu: 1'b0, imm: 64'd0, ill: 1'b0};

    // kinds: ADDi SUBi ADDr SUBr LDUR STUR MOVZ CBZ B
    localparam logic [31:0] PAT_MASK [9] = '{32'hFF800000, 32'hFF800000, 32'hFFE0FC00,
        32'hFFE0FC00, 32'hFFE00C00, 32'hFFE00C00, 32'hFF800000, 32'hFF000000, 32'hFC000000};
    localparam logic [31:0] PAT_MATCH [9] = '{32'h91000000, 32'hD1000000, 32'h8B000000,
        32'hCB000000, 32'hF8400000, 32'hF8000000, 32'hD2800000, 32'hB4000000, 32'h14000000};
    localparam logic [3:0] OP_OF [9] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};

    decode_stage dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .in_pc           (in_pc),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .Read_register_1 (Read_register_1),
        .Read_register_2 (Read_register_2),
        .Write_register  (Write_register),
        .RegWrite        (RegWrite),
        .UseSP           (UseSP),
        .alu_src         (alu_src),
        .op              (op),
        .imm             (imm),
        .illegal         (illegal)
    );

    always #5 clk = ~clk;

    function automatic dec_t observed();
        return {op, Read_register_1, Read_register_2, Write_register,
                RegWrite, UseSP, alu_src, imm, illegal};
    endfunction

    // Reference decoder: expected fields e and mask m of fields the rules define.
    function automatic void ref_decode(input logic [31:0] ins, output dec_t e, output dec_t m);
        int     kind;
        logic   dest;
        logic   [4:0] rd;
        logic   [4:0] rn;
        longint v;
        rd   = ins[4:0];
        rn   = ins[9:5];
        kind = -1;
        dest = 1'b0;
        for (int i = 0; i < 9; i++)
            if (kind < 0 && (ins & PAT_MASK[i]) == PAT_MATCH[i]) kind = i;
        e     = RESET_VAL;
        e.rr1 = rn;
        m     = '1;
        if (kind == 5 && rn == 5'd31 && rd == 5'd31) kind = -1;
        if (kind >= 0) e.op = OP_OF[kind];
        case (kind)
            0, 1: begin
                e.imm = 64'(ins[21:10]);
                if (ins[22]) e.imm = e.imm * 64'd4096;
                e.sp  = 1'b1;
                e.alu = 1'b1;
                dest  = 1'b1;
            end
            2, 3: begin
                e.rr2 = ins[20:16];
                dest  = 1'b1;
            end
            4, 5: begin
                v = longint'(ins[20:12]);
                if (v >= 256) v = v - 512;
                e.imm = 64'(v);
                e.alu = 1'b1;
                if (kind == 4) begin
                    e.sp = 1'b1;
                    dest = 1'b1;
                end else begin
                    e.sp  = (rn == 5'd31);
                    e.rr2 = rd;
                end
            end
            6: begin
                e.imm = 64'(ins[20:5]);
                repeat (int'(ins[22:21])) e.imm = e.imm * 64'd65536;
                e.alu = 1'b1;
                dest  = 1'b1;
                m.rr1 = '0;
            end
            7: begin
                v = longint'(ins[23:5]);
                if (v >= 262144) v = v - 524288;
                e.imm = 64'(v * 4);
                e.rr1 = rd;
                m.sp  = 1'b0;
                m.alu = 1'b0;
            end
            8: begin
                v = longint'(ins[25:0]);
                if (v >= 33554432) v = v - 67108864;
                e.imm = 64'(v * 4);
                m.rr1 = '0;
                m.sp  = 1'b0;
                m.alu = 1'b0;
            end
            default: begin
                e.ill = 1'b1;
                m.rr1 = '0;
                m.sp  = 1'b0;
                m.alu = 1'b0;
            end
        endcase
        if (dest && !(rd == 5'd31 && !e.sp)) begin
            e.rw = 1'b1;
            e.wr = rd;
        end
    endfunction

    function automatic logic [31:0] gen_instr();
        int unsigned k;
        logic [31:0] ins;
        k = $urandom_range(0, 9);
        if (k < 9) ins = PAT_MATCH[k] | ($urandom & ~PAT_MASK[k]);
        else       ins = $urandom;
        if ($urandom_range(0, 3) == 0) ins[4:0] = 5'd31;
        if ($urandom_range(0, 3) == 0) ins[9:5] = 5'd31;
        return ins;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        @(negedge clk);
        tests++; if (observed() !== RESET_VAL) begin fails++; $display("FAIL reset.fields: got %h want %h", observed(), RESET_VAL); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset.valid: got %b want 0", out_valid); end
        tests++; if (out_pc !== 64'd0) begin fails++; $display("FAIL reset.pc: got %h want 0", out_pc); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset.in_ready: got %b want 1", in_ready); end
        in_valid = 1'b1; in_instr = 32'h910043E0;
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset.no_accept: got %b want 0", out_valid); end
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset.ready_after: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_add_imm();
        dec_t e, m;
        ref_decode(32'h910043E0, e, m);
        in_valid = 1'b1; in_instr = 32'h910043E0; in_pc = 64'h1000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_imm.valid: got %b want 1", out_valid); end
        tests++; if (op !== 4'd1) begin fails++; $display("FAIL add_imm.op: got %0d want 1", op); end
        tests++; if (Read_register_1 !== 5'd31 || UseSP !== 1'b1) begin fails++; $display("FAIL add_imm.rn_sp: got %0d/%b want 31/1", Read_register_1, UseSP); end
        tests++; if (imm !== 64'd16) begin fails++; $display("FAIL add_imm.imm: got %h want 10", imm); end
        tests++; if (Write_register !== 5'd0 || RegWrite !== 1'b1) begin fails++; $display("FAIL add_imm.wr: got %0d/%b want 0/1", Write_register, RegWrite); end
        tests++; if ((observed() & m) !== (e & m)) begin fails++; $display("FAIL add_imm.model: got %h want %h", observed() & m, e & m); end
        tests++; if (out_pc !== 64'h1000) begin fails++; $display("FAIL add_imm.pc: got %h want 1000", out_pc); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_imm.drain: got %b want 0", out_valid); end
    endtask

    task automatic test_ldur_movz();
        in_valid = 1'b1; in_instr = 32'hF85F83E1; in_pc = 64'h2000; out_ready = 1'b1;
        tick();
        in_instr = 32'hD2A00022; in_pc = 64'h2004;
        #1;
        tests++; if (op !== 4'd3 || imm !== 64'hFFFFFFFFFFFFFFF8) begin fails++; $display("FAIL ldur.imm: got op %0d imm %h want 3 fffffffffffffff8", op, imm); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ldur.in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_pc !== 64'h2004) begin fails++; $display("FAIL movz.b2b: got valid %b pc %h want 1 2004", out_valid, out_pc); end
        tests++; if (op !== 4'd5 || imm !== 64'h10000) begin fails++; $display("FAIL movz.imm: got op %0d imm %h want 5 10000", op, imm); end
        tests++; if (Write_register !== 5'd2 || RegWrite !== 1'b1) begin fails++; $display("FAIL movz.wr: got %0d/%b want 2/1", Write_register, RegWrite); end
        tick();
    endtask

    task automatic test_xzr();
        in_valid = 1'b1; in_instr = 32'h8B02003F; in_pc = 64'h3000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if (RegWrite !== 1'b0 || UseSP !== 1'b0) begin fails++; $display("FAIL xzr.rw_sp: got %b/%b want 0/0", RegWrite, UseSP); end
        tests++; if (op !== 4'd1 || Read_register_2 !== 5'd2 || Write_register !== 5'd31) begin fails++; $display("FAIL xzr.fields: got op %0d rm %0d wr %0d want 1 2 31", op, Read_register_2, Write_register); end
        tick();
    endtask

    task automatic test_stur_illegal();
        in_valid = 1'b1; in_instr = 32'hF80003FF; in_pc = 64'h3004; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if (illegal !== 1'b1 || op !== 4'd0) begin fails++; $display("FAIL stur31.illegal: got ill %b op %0d want 1 0", illegal, op); end
        tests++; if (RegWrite !== 1'b0 || imm !== 64'd0) begin fails++; $display("FAIL stur31.rw_imm: got %b %h want 0 0", RegWrite, imm); end
        tick();
    endtask

    task automatic test_stall_flush();
        dec_t e, m;
        ref_decode(32'hD1000C21, e, m);
        in_valid = 1'b1; in_instr = 32'hD1000C21; in_pc = 64'h4000; out_ready = 1'b0;
        tick();
        in_instr = 32'h14000001; in_pc = 64'h4004;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall.in_ready[%0d]: got %b want 0", i, in_ready); end
            tick();
            tests++; if (out_valid !== 1'b1 || out_pc !== 64'h4000 || (observed() & m) !== (e & m)) begin
                fails++; $display("FAIL stall.hold[%0d]: got v%b pc %h %h want v1 pc 4000 %h", i, out_valid, out_pc, observed() & m, e & m);
            end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush.valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush.in_ready: got %b want 1", in_ready); end
        flush = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_acc.in_ready: got %b want 1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_acc.valid: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back(input int n, input string tag);
        item_t q[$];
        item_t it;
        int    sent = 0;
        int    got = 0;
        bit    pending = 1'b0;
        for (int cyc = 0; cyc < n * 20 + 50 && got < n; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!pending && sent < n && $urandom_range(0, 3) != 0) begin
                pending  = 1'b1;
                in_instr = gen_instr();
                in_pc    = {$urandom, $urandom};
            end
            in_valid = pending;
            #1;
            tests++; if (out_valid !== (q.size() != 0)) begin fails++; $display("FAIL %s.valid cyc %0d: got %b want %b", tag, cyc, out_valid, q.size() != 0); end
            if (q.size() != 0 && out_valid) begin
                tests++; if ((observed() & q[0].m) !== (q[0].e & q[0].m)) begin
                    fails++; $display("FAIL %s.fields cyc %0d: got %h want %h", tag, cyc, observed() & q[0].m, q[0].e & q[0].m);
                end
                tests++; if (out_pc !== q[0].pc) begin fails++; $display("FAIL %s.pc cyc %0d: got %h want %h", tag, cyc, out_pc, q[0].pc); end
                if (out_ready) begin
                    void'(q.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                ref_decode(in_instr, it.e, it.m);
                it.pc = in_pc;
                q.push_back(it);
                sent++;
                pending = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        tests++; if (got !== n) begin fails++; $display("FAIL %s.count: got %0d want %0d", tag, got, n); end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; in_instr = 32'h8B020020; in_pc = 64'h5000; out_ready = 1'b1;
        tick();
        in_instr = 32'hF85F83E1; in_pc = 64'h5004; out_ready = 1'b0;
        tick();
        tests++; if (out_valid !== 1'b1 || out_pc !== 64'h5000) begin fails++; $display("FAIL midreset.pre: got v%b pc %h want v1 5000", out_valid, out_pc); end
        #2 reset = 1'b1;
        #1;
        tests++; if (observed() !== RESET_VAL || out_pc !== 64'd0) begin fails++; $display("FAIL midreset.async: got %h pc %h want %h pc 0", observed(), out_pc, RESET_VAL); end
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL midreset.hs: got v%b r%b want v0 r1", out_valid, in_ready); end
        @(posedge clk);
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset.no_accept: got %b want 0", out_valid); end
        reset = 1'b0;
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || imm !== 64'hFFFFFFFFFFFFFFF8 || out_pc !== 64'h5004) begin
            fails++; $display("FAIL midreset.resume: got v%b imm %h pc %h want v1 fffffffffffffff8 5004", out_valid, imm, out_pc);
        end
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_ldur_movz();
        test_xzr();
        test_stur_illegal();
        test_stall_flush();
        test_back_to_back(8, "b2b8");
        test_reset_midstream();
        test_back_to_back(300, "rand");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
